// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce: pushbutton synchroniser, debounce FSM, press/release/long
// pulses and wrapping press counter.            Revision: 1.0
// ============================================================================
module btn_debounce #(
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 250000,
   parameter int LONG_PRESS_CYCLES = 25000000,
   parameter int ACTIVE_LOW        = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   output logic       btn_level,
   output logic       btn_press,
   output logic       btn_release,
   output logic       btn_long,
   output logic [7:0] press_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam int HW = (LONG_PRESS_CYCLES < 2) ? 1 : $clog2(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = (LONG_PRESS_CYCLES < 1) ? '0 : HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam bit LONG_EN = (LONG_PRESS_CYCLES != 0);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [HW-1:0]          hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], btn_raw ^ (ACTIVE_LOW != 0)};
      end
   end

   assign s = sync[SYNC_STAGES-1];

   // Entering a wait state already counts the first stable cycle, so the
   // level moves exactly DEBOUNCE_CYCLES edges after s first shows the change.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RELEASED;
         cnt         <= '0;
         hold        <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;
         press_count <= 8'd0;
      end else begin
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;

         if (LONG_EN && btn_level && (hold != HOLD_LAST)) begin
            hold <= hold + HOLD_ONE;
            if ((hold + HOLD_ONE) == HOLD_LAST) begin
               btn_long <= 1'b1;
            end
         end

         case (state)
            RELEASED: begin
               if (s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state       <= PRESSED;
                     btn_level   <= 1'b1;
                     btn_press   <= 1'b1;
                     press_count <= press_count + 8'd1;
                     hold        <= '0;
                     btn_long    <= (LONG_PRESS_CYCLES == 1);
                  end else begin
                     state <= PRESS_WAIT;
                     cnt   <= CNT_ONE;
                  end
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state <= RELEASED;
               end else if (cnt == CNT_LAST) begin
                  state       <= PRESSED;
                  btn_level   <= 1'b1;
                  btn_press   <= 1'b1;
                  press_count <= press_count + 8'd1;
                  hold        <= '0;
                  btn_long    <= (LONG_PRESS_CYCLES == 1);
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state       <= RELEASED;
                     btn_level   <= 1'b0;
                     btn_release <= 1'b1;
                  end else begin
                     state <= RELEASE_WAIT;
                     cnt   <= CNT_ONE;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state <= PRESSED;
               end else if (cnt == CNT_LAST) begin
                  state       <= RELEASED;
                  btn_level   <= 1'b0;
                  btn_release <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// tb_btn_debounce: scoreboard bench for btn_debounce, active-high and
// active-low instances driven by complementary pad levels.  Revision: 1.0
// ============================================================================
module tb_btn_debounce;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LP   = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic raw = 1'b0;
   logic raw_n;
   assign raw_n = ~raw;

   logic       level0, press0, rel0, long0;
   logic [7:0] count0;
   logic       level1, press1, rel1, long1;
   logic [7:0] count1;

   always #5 clk = ~clk;

   btn_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                  .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .btn_raw(raw),
      .btn_level(level0), .btn_press(press0), .btn_release(rel0),
      .btn_long(long0), .press_count(count0));

   btn_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
                  .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst), .btn_raw(raw_n),
      .btn_level(level1), .btn_press(press1), .btn_release(rel1),
      .btn_long(long1), .press_count(count1));

   typedef struct packed {
      logic       level;
      logic       press;
      logic       rel;
      logic       lng;
      logic [7:0] count;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   press_seen = 0;
   int   long_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the level flips once the last DEB pad samples, seen SYNC
   // edges late, all disagree with it; long fires LP-1 edges after a press.
   logic samp[$];
   int   edge_n = 0;
   logic m_level = 1'b0;
   logic [7:0] m_count = 8'd0;
   int   press_edge = -1000;

   always @(posedge clk) begin : model
      exp_t e;
      logic ch;
      edge_n++;
      e = '0;
      if (rst) begin
         samp.delete();
         for (int i = 0; i < SYNC + DEB; i++) samp.push_back(1'b0);
         m_level    = 1'b0;
         m_count    = 8'd0;
         press_edge = -1000;
      end else begin
         samp.push_back(raw);
         void'(samp.pop_front());
         ch = 1'b1;
         for (int i = 0; i < DEB; i++) if (samp[i] == m_level) ch = 1'b0;
         e.lng = m_level && ((edge_n - press_edge) == LP - 1);
         if (ch) begin
            m_level = !m_level;
            if (m_level) begin
               e.press    = 1'b1;
               m_count    = m_count + 8'd1;
               press_edge = edge_n;
            end else begin
               e.rel = 1'b1;
            end
         end
         e.level = m_level;
         e.count = m_count;
      end
      q.push_back(e);
   end

   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (q.size() == 0) begin
         check("queue_empty", 32'd1, 32'd0);
      end else begin
         e = q.pop_front();
         check("level",    level0, e.level);
         check("press",    press0, e.press);
         check("release",  rel0,   e.rel);
         check("long",     long0,  e.lng);
         check("count",    count0, e.count);
         check("al_level", level1, e.level);
         check("al_press", press1, e.press);
         check("al_release", rel1, e.rel);
         check("al_long",  long1,  e.lng);
         check("al_count", count1, e.count);
         if (press0) press_seen++;
         if (long0)  long_seen++;
      end
   end

   task automatic drive(input logic v, input int n);
      raw = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic measure(input logic v, input int exp_edges, input string name);
      int got;
      got = -1;
      raw = v;
      for (int i = 1; i <= 40 && got < 0; i++) begin
         @(posedge clk);
         #1;
         if (level0 === v && level1 === v) got = i;
      end
      check(name, got, exp_edges);
      @(negedge clk);
   endtask

   initial begin : stim
      int p0, l0;
      logic [7:0] c0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_level", level0, 0);
      check("reset_count", count0, 0);

      // clean press and release
      measure(1'b1, SYNC + DEB, "s1_press_latency");
      check("s1_count", count0, 1);
      drive(1'b1, 3);
      measure(1'b0, SYNC + DEB, "s1_release_latency");
      drive(1'b0, 4);

      // bounce before settling high
      p0 = press_seen;
      drive(1'b1, 3);
      drive(1'b0, 1);
      measure(1'b1, SYNC + DEB, "s2_bounce_latency");
      check("s2_press_pulses", press_seen - p0, 1);
      drive(1'b1, 2);
      measure(1'b0, SYNC + DEB, "s2_release_latency");
      drive(1'b0, 8);

      // long press held well past the threshold
      l0 = long_seen;
      measure(1'b1, SYNC + DEB, "s3_press_latency");
      drive(1'b1, 20);
      measure(1'b0, SYNC + DEB, "s3_release_latency");
      check("s3_long_once", long_seen - l0, 1);
      drive(1'b0, 8);

      // release landing on the same edge as the long pulse
      l0 = long_seen;
      measure(1'b1, SYNC + DEB, "s3b_press_latency");
      drive(1'b1, 3);
      measure(1'b0, SYNC + DEB, "s3b_release_latency");
      check("s3b_long_once", long_seen - l0, 1);
      drive(1'b0, 8);

      // reset while waiting out a press
      drive(1'b1, 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("s4_level", level0, 0);
      check("s4_count", count0, 0);
      check("s4_al_count", count1, 0);
      measure(1'b1, SYNC + DEB, "s4_repress_latency");
      check("s4_count_after", count0, 1);
      drive(1'b1, 2);
      measure(1'b0, SYNC + DEB, "s4_release_latency");
      drive(1'b0, 4);

      // 256 presses wrap the counter back to its start value
      p0 = press_seen;
      c0 = count0;
      repeat (256) begin
         drive(1'b1, 7);
         drive(1'b0, 7);
      end
      check("s5_press_pulses", press_seen - p0, 256);
      check("s5_count_wrap", count0, c0);

      // random bouncing
      repeat (80) drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      drive(1'b0, 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
